uart_command: RTL

- Byte-level command controller between the UART receiver and the UART transmitter.
- Parses a small serial protocol into writes and reads of an internal bank of 8-bit control registers, and sequences the response byte back to the transmitter.
- The register bank drives board-level outputs such as the LEDs.
- Sits between the receive and transmit instances in the board top level.

---
 rtl/uart_command.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_command.sv
// Byte-level command controller: parses 'W' addr data / 'R' addr packets from the UART receiver
// into a bank of 8-bit registers and returns one response byte per packet to the transmitter.
module uart_command #(
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 25000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rcv_stb,
    input  logic [7:0]                    rcv_dat,
    output logic                          rcv_rdy,
    output logic                          xmt_stb,
    output logic [7:0]                    xmt_dat,
    input  logic                          xmt_rdy,
    output logic [8*(2**ADDR_WIDTH)-1:0]  regs,
    output logic                          wr_stb,
    output logic [ADDR_WIDTH-1:0]         wr_adr,
    output logic [7:0]                    err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [1:0] {CMD, ADDR, DATA, RESP} state_t;

    // Handshake: a byte moves on a rising edge only when its strobe and the
    // matching ready are both high; xmt_stb/xmt_dat hold until that edge.
    state_t         state;
    logic           is_write;
    logic [7:0]     adr_q;
    logic [TW-1:0]  tmo_cnt;
    logic           rcv_xfer;
    logic           xmt_xfer;

    assign rcv_xfer = rcv_stb && rcv_rdy;
    assign xmt_xfer = xmt_stb && xmt_rdy;

    function automatic logic adr_bad(input logic [7:0] a);
        return (a >> ADDR_WIDTH) != 8'd0;
    endfunction

    function automatic logic [7:0] err_next(input logic [7:0] e);
        return (e == 8'hFF) ? e : e + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= CMD;
            regs     <= '0;
            err      <= 8'd0;
            tmo_cnt  <= '0;
            wr_stb   <= 1'b0;
            wr_adr   <= '0;
            xmt_stb  <= 1'b0;
            xmt_dat  <= 8'd0;
            rcv_rdy  <= 1'b0;
            is_write <= 1'b0;
            adr_q    <= 8'd0;
        end else begin
            wr_stb <= 1'b0;
            case (state)
                CMD: begin
                    rcv_rdy <= 1'b1;
                    tmo_cnt <= '0;
                    if (rcv_xfer) begin
                        if (rcv_dat == CMD_W || rcv_dat == CMD_R) begin
                            state    <= ADDR;
                            is_write <= (rcv_dat == CMD_W);
                        end else begin
                            state   <= RESP;
                            rcv_rdy <= 1'b0;
                            xmt_stb <= 1'b1;
                            xmt_dat <= RSP_ERR;
                            err     <= err_next(err);
                        end
                    end
                end
                ADDR, DATA: begin
                    if (rcv_xfer) begin
                        tmo_cnt <= '0;
                        if (state == ADDR) begin
                            adr_q <= rcv_dat;
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                state   <= RESP;
                                rcv_rdy <= 1'b0;
                                xmt_stb <= 1'b1;
                                if (adr_bad(rcv_dat)) begin
                                    xmt_dat <= RSP_ERR;
                                    err     <= err_next(err);
                                end else begin
                                    xmt_dat <= regs[{rcv_dat[ADDR_WIDTH-1:0], 3'b000} +: 8];
                                end
                            end
                        end else begin
                            state   <= RESP;
                            rcv_rdy <= 1'b0;
                            xmt_stb <= 1'b1;
                            if (adr_bad(adr_q)) begin
                                xmt_dat <= RSP_ERR;
                                err     <= err_next(err);
                            end else begin
                                regs[{adr_q[ADDR_WIDTH-1:0], 3'b000} +: 8] <= rcv_dat;
                                wr_stb  <= 1'b1;
                                wr_adr  <= adr_q[ADDR_WIDTH-1:0];
                                xmt_dat <= RSP_OK;
                            end
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        // Stalled packet: drop it silently and count the error.
                        state   <= CMD;
                        tmo_cnt <= '0;
                        err     <= err_next(err);
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: begin
                    if (xmt_xfer) begin
                        state   <= CMD;
                        xmt_stb <= 1'b0;
                        rcv_rdy <= 1'b1;
                    end
                end
                default: state <= CMD;
            endcase
        end
    end
endmodule
